// File: rtl/gpio_bidir_pio.sv
// Bidirectional GPIO port on an Avalon-MM slave: per-bit direction, atomic set/clear,
// synchronised input sampling, sticky edge capture and a maskable level interrupt.
module gpio_bidir_pio #(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_MAX + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] ecap_clr;
    logic [CW-1:0]    warm_cnt;
    logic             warm_done;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT[WIDTH-1:0];
            data_dir <= RESET_DIR[WIDTH-1:0];
            irqmask  <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out <= wdata;
                ADDR_DIR:     data_dir <= wdata;
                ADDR_IRQMASK: irqmask  <= wdata;
                ADDR_OUTSET:  data_out <= data_out | wdata;
                ADDR_OUTCLR:  data_out <= data_out & ~wdata;
                default: ;
            endcase
        end
    end

    // Driven pins come back through the same synchroniser, so DATA reads show real pin state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= bidir_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= sync;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Hold off capture until the chain and prev hold real pin samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + CW'(1);
        end
    end

    assign warm_done = (warm_cnt == CW'(WARM_MAX));

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = sync & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~sync & prev;
        end else begin
            edge_det = sync ^ prev;
        end
    end

    assign ecap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    // A new edge beats a same-cycle clear of that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            edgecapture <= (edgecapture & ~ecap_clr) | (warm_done ? edge_det : '0);
            irq         <= |(edgecapture & irqmask);
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:    rd_word[WIDTH-1:0] = sync;
            ADDR_DIR:     rd_word[WIDTH-1:0] = data_dir;
            ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecapture;
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_word;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign bidir_port[g] = data_dir[g] ? data_out[g] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_bidir_pio.sv
// Bench for gpio_bidir_pio: pin-history model checked every cycle plus directed literal checks.
module tb_gpio_bidir_pio;

    localparam int          W  = 8;
    localparam int          SS = 2;
    localparam int          ET = 0;
    localparam logic [W-1:0] ROUT = 8'h5A;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    wire  [W-1:0] pins;
    logic [W-1:0] ext;
    logic [W-1:0] tb_dir;

    logic [31:0] readdata2;
    logic        irq2;
    wire  [W-1:0] pins2;
    logic [W-1:0] ext2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gpio_bidir_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(ET),
                     .RESET_OUT({24'h0, ROUT}), .RESET_DIR(32'h0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .bidir_port(pins)
    );

    gpio_bidir_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2),
                     .RESET_OUT(32'h0), .RESET_DIR(32'h0)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(3'd3), .chipselect(1'b0),
        .write_n(1'b1), .writedata(32'h0), .readdata(readdata2), .irq(irq2),
        .bidir_port(pins2)
    );

    // External drivers release a pin whenever the DUT owns it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_dir <= '0;
        else if (chipselect && !write_n && address == 3'd1) tb_dir <= writedata[W-1:0];
    end

    for (genvar g = 0; g < W; g++) begin : g_ext
        assign pins[g] = tb_dir[g] ? 1'bz : ext[g];
    end
    assign pins2 = ext2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: registers as plain values, pin history as a list of past pin samples.
    logic [W-1:0] m_out, m_dir, m_mask, m_ecap;
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] hist [SS+2];
    int           m_edges;
    logic [2:0]   in_addr;
    logic         in_cs, in_wn;
    logic [31:0]  in_wd;
    logic [W-1:0] in_pin;

    function automatic logic [W-1:0] exp_pins();
        return (m_dir & m_out) | (~m_dir & ext);
    endfunction

    task automatic model_reset();
        m_out = ROUT; m_dir = '0; m_mask = '0; m_ecap = '0;
        m_rd = '0; m_irq = 1'b0; m_edges = 0;
        for (int j = 0; j < SS + 2; j++) hist[j] = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, pv, ed, wd;
        logic wr;
        for (int j = SS + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_pin;
        if (m_edges < 1000) m_edges++;
        s  = hist[SS];
        pv = hist[SS+1];
        if (ET == 0)      ed = s & ~pv;
        else if (ET == 1) ed = ~s & pv;
        else              ed = s ^ pv;
        if (m_edges < SS + 2) ed = '0;
        wd = in_wd[W-1:0];
        wr = in_cs && !in_wn;
        case (in_addr)
            3'd0:    m_rd = {24'h0, s};
            3'd1:    m_rd = {24'h0, m_dir};
            3'd2:    m_rd = {24'h0, m_mask};
            3'd3:    m_rd = {24'h0, m_ecap};
            default: m_rd = 32'h0;
        endcase
        m_irq = |(m_ecap & m_mask);
        if (wr && in_addr == 3'd3) m_ecap = m_ecap & ~wd;
        m_ecap = m_ecap | ed;
        if (wr) begin
            case (in_addr)
                3'd0: m_out = wd;
                3'd1: m_dir = wd;
                3'd2: m_mask = wd;
                3'd4: m_out = m_out | wd;
                3'd5: m_out = m_out & ~wd;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step();
            check("rd", readdata, m_rd);
            check("irq", 32'(irq), 32'(m_irq));
            check("pins", 32'(pins), 32'(exp_pins()));
        end
        in_addr = address;
        in_cs   = chipselect;
        in_wn   = write_n;
        in_wd   = writedata;
        in_pin  = exp_pins();
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        ext = 8'h00; ext2 = 8'hFF;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        repeat (10) cyc();
        check("warm_ecap_any", readdata2, 32'h0);
        check("warm_irq_any", 32'(irq2), 32'h0);
        ext2 = 8'hFE;
        repeat (4) cyc();
        check("any_fall_ecap", readdata2, 32'h01);

        wr(3'd1, 32'hFF);
        check("dir_pins_reset_out", 32'(pins), 32'h5A);
        wr(3'd0, 32'hA5);
        check("data_pins", 32'(pins), 32'hA5);
        cyc(); cyc();
        check("data_rd_old", readdata, 32'h5A);
        cyc();
        check("data_rd_new", readdata, 32'hA5);

        wr(3'd4, 32'h0A);
        check("outset_pins", 32'(pins), 32'hAF);
        check("outset_rd", readdata, 32'h0);
        wr(3'd5, 32'h81);
        check("outclr_pins", 32'(pins), 32'h2E);
        check("outclr_rd", readdata, 32'h0);
        address = 3'd3;
        repeat (4) cyc();
        check("ecap_from_drive", readdata, 32'hFF);

        wr(3'd1, 32'h0);
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h04);
        address = 3'd3;
        repeat (6) cyc();
        check("ecap_cleared", readdata, 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        ext = 8'h04;
        cyc(); check("edge_irq_k", 32'(irq), 32'h0);
        cyc(); check("edge_irq_k1", 32'(irq), 32'h0);
        cyc(); check("edge_irq_k2", 32'(irq), 32'h0);
        check("edge_rd_k2", readdata, 32'h0);
        cyc(); check("edge_irq_k3", 32'(irq), 32'h1);
        check("edge_rd_k3", readdata, 32'h04);

        ext = 8'h00;
        repeat (4) cyc();
        ext = 8'h04;
        cyc(); cyc();
        wr(3'd3, 32'h04);
        check("coincide_irq", 32'(irq), 32'h1);
        address = 3'd3;
        cyc();
        check("coincide_ecap", readdata, 32'h04);
        check("coincide_irq_next", 32'(irq), 32'h1);
        wr(3'd3, 32'h04);
        check("clear_irq_hold", 32'(irq), 32'h1);
        cyc();
        check("clear_irq_drop", 32'(irq), 32'h0);
        check("clear_rd", readdata, 32'h0);

        ext = 8'h00;
        repeat (3) cyc();
        ext = 8'h04;
        repeat (5) cyc();
        check("rearm_irq", 32'(irq), 32'h1);
        wr(3'd1, 32'hFF);
        address = 3'd1;
        cyc();
        check("pre_rst_rd", readdata, 32'hFF);

        address = 3'd0; writedata = 32'hC3; chipselect = 1'b1; write_n = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_rd", readdata, 32'h0);
        check("rst_async_irq", 32'(irq), 32'h0);
        check("rst_async_rd_any", readdata2, 32'h0);
        chipselect = 1'b0; write_n = 1'b1; address = 3'd1; writedata = 32'h0;
        ext = 8'h3C;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cyc();
        check("rst_dir", readdata, 32'h0);
        address = 3'd2;
        cyc();
        check("rst_mask", readdata, 32'h0);
        address = 3'd3;
        repeat (8) cyc();
        check("rst_ecap", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ecap_any", readdata2, 32'h0);
        check("rst_pins_released", 32'(pins), 32'h3C);

        wr(3'd1, 32'hFF);
        address = 3'd0;
        check("rst_out_pins", 32'(pins), 32'h5A);
        repeat (3) cyc();
        check("rst_out_readback", readdata, 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
